// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
// FSM state encoding, parity modes and parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // True when a parameter set describes a frame the receiver supports.
  function automatic bit rx_params_ok(
    input int cpb,
    input int db,
    input int par,
    input int sb
  );
    return (cpb >= 8) &&
           (db >= 5) && (db <= 9) &&
           (par >= PAR_NONE) && (par <= PAR_EVEN) &&
           ((sb == 1) || (sb == 2));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, falling-edge detect, bit value.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over consecutive samples.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic fall,
  output logic bit_val
);

  logic sync1;
  logic sync2;
  logic hist1;
`ifdef UART_RX_MAJORITY_EN
  logic hist2;
`endif

  // Two-flop synchroniser plus sample history; everything resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist1 <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      hist2 <= 1'b1;
`endif
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      hist1 <= sync2;
`ifdef UART_RX_MAJORITY_EN
      hist2 <= hist1;
`endif
    end
  end

  assign fall = hist1 & ~sync2;

`ifdef UART_RX_MAJORITY_EN
  // Vote over the samples taken one cycle before, at, and after target.
  assign bit_val = (sync2 & hist1) |
                   (sync2 & hist2) |
                   (hist1 & hist2);
`else
  assign bit_val = sync2;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver (data/parity/stop bits).
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority bit sampling.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam bit PARAMS_OK =
    rx_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("uart_rx_param: illegal parameter set");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS);

  // The vote needs one extra sample, so the start decision moves one
  // cycle later; later bits keep a full bit period between decisions.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_T = CLKS_PER_BIT / 2;
`else
  localparam int START_T = CLKS_PER_BIT / 2 - 1;
`endif
  localparam int BIT_T = CLKS_PER_BIT - 1;

  localparam logic [CW-1:0] START_C = CW'(START_T);
  localparam logic [CW-1:0] BIT_C   = CW'(BIT_T);
  localparam logic [IW-1:0] LAST_C  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LC = 1'(STOP_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 pe_next;
  logic                 fall;
  logic                 bit_val;
  logic                 at_start;
  logic                 at_bit;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .fall    (fall),
    .bit_val (bit_val)
  );

  assign at_start = (cnt == START_C);
  assign at_bit   = (cnt == BIT_C);
  assign busy     = (state != ST_IDLE);

  // Parity verdict from the assembled word and the received parity bit.
  always_comb begin
    pe_next = 1'b0;
    unique case (1'b1)
      (PARITY == PAR_ODD):  pe_next = ~(^shreg ^ par_bit);
      (PARITY == PAR_EVEN): pe_next = ^shreg ^ par_bit;
      default:              pe_next = 1'b0;
    endcase
  end

  // Frame FSM: bit timing counter, shift register and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (at_start) begin
            cnt <= '0;
            if (bit_val) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (at_bit) begin
            cnt   <= '0;
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_C) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              ferr_acc <= 1'b0;
              state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (at_bit) begin
            cnt     <= '0;
            par_bit <= bit_val;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (at_bit) begin
            cnt <= '0;
            if (stop_idx == STOP_LC) begin
              state      <= ST_IDLE;
              rx_valid   <= 1'b1;
              rx_data    <= shreg;
              parity_err <= pe_next;
              frame_err  <= ferr_acc | ~bit_val;
            end else begin
              stop_idx <= 1'b1;
              ferr_acc <= ferr_acc | ~bit_val;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized scoreboard bench for uart_rx_param.
// Two receivers: 8N1 and 8E2, each with its own expected-frame queue.
module tb_uart_rx_param;

  localparam int CPB = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       pe_a, pe_b;
  logic       fe_a, fe_b;
  logic       busy_a, busy_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  exp_t       e_a, e_b;
  int         n_checks = 0;
  int         n_errors = 0;
  int         sent_a = 0, sent_b = 0;
  int         seen_a = 0, seen_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst), .uart_rx(line_a),
    .rx_data(data_a), .rx_valid(valid_a),
    .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst), .uart_rx(line_b),
    .rx_data(data_b), .rx_valid(valid_b),
    .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitors: pop the oldest expected frame whenever a receiver reports one.
  always @(negedge clk) begin
    if (valid_a) begin
      seen_a++;
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_valid: got rx_valid=1 expected none");
      end else begin
        e_a = q_a.pop_front();
        check("a_data", data_a, e_a.d);
        check("a_parity_err", pe_a, e_a.pe);
        check("a_frame_err", fe_a, e_a.fe);
        check("a_busy_at_valid", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      seen_b++;
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_valid: got rx_valid=1 expected none");
      end else begin
        e_b = q_b.pop_front();
        check("b_data", data_b, e_b.d);
        check("b_parity_err", pe_b, e_b.pe);
        check("b_frame_err", fe_b, e_b.fe);
        check("b_busy_at_valid", busy_b, 0);
      end
    end
  end

  task automatic hold(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(bit sel, logic v);
    if (sel) line_b = v;
    else line_a = v;
  endtask

  // One bit period; optionally a single inverted cycle at the bit centre.
  task automatic send_bit(bit sel, logic v, bit gl);
    if (gl) begin
      drive(sel, v);
      hold(CPB / 2);
      drive(sel, ~v);
      hold(1);
      drive(sel, v);
      hold(CPB / 2 - 1);
    end else begin
      drive(sel, v);
      hold(CPB);
    end
  endtask

  // Reference model: expected word and flags from the frame content,
  // queued before the frame goes out on the line.
  task automatic send_exp(bit sel, logic [7:0] d, logic pbit,
                          logic s0, logic s1, bit gl, int gap);
    exp_t e;
    e.d = d;
    if (sel) begin
      e.pe = (($countones(d) + int'(pbit)) % 2) == 1;
      e.fe = (s0 == 1'b0) || (s1 == 1'b0);
      q_b.push_back(e);
      sent_b++;
      last_b = d;
    end else begin
      e.pe = 1'b0;
      e.fe = (s0 == 1'b0);
      q_a.push_back(e);
      sent_a++;
      last_a = d;
    end
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], gl);
    if (sel) send_bit(sel, pbit, gl);
    send_bit(sel, s0, 1'b0);
    if (sel) send_bit(sel, s1, 1'b0);
    drive(sel, 1'b1);
    if (gap > 0) hold(gap);
  endtask

  task automatic wait_drain(bit sel);
    for (int i = 0; i < 4 * CPB; i++) begin
      if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout_%0d: got %0d pending expected 0",
             sel, sel ? q_b.size() : q_a.size());
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s0, s1;
    bit         sel;
    int         gap;

    rst = 1'b1;
    hold(5);
    rst = 1'b0;
    hold(2);
    check("rst_data_a", data_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_pe_a", pe_a, 0);
    check("rst_fe_a", fe_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_busy_b", busy_b, 0);

    send_exp(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, CPB);
    wait_drain(0);
    check("a5_one_valid", seen_a, 1);
    check("a5_busy_idle", busy_a, 0);

    drive(0, 1'b0);
    hold(4);
    drive(0, 1'b1);
    hold(2);
    check("glitch_busy_hi", busy_a, 1);
    hold(6);
    check("glitch_busy_lo", busy_a, 0);
    hold(CPB);
    check("glitch_no_valid", seen_a, sent_a);
    check("glitch_data_hold", data_a, last_a);

    send_exp(1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, CPB);
    send_exp(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, CPB);
    wait_drain(1);

    send_exp(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 2 * CPB);
    send_exp(0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, CPB);
    wait_drain(0);
    check("hold_fe_a", fe_a, 0);
    check("hold_data_a", data_a, 8'h81);

    d = 8'h55;
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, d[i], 1'b0);
    drive(0, d[3]);
    hold(CPB / 2);
    rst = 1'b1;
    drive(0, 1'b1);
    hold(3);
    rst = 1'b0;
    last_a = 8'h00;
    last_b = 8'h00;
    hold(2 * CPB);
    check("midrst_busy", busy_a, 0);
    check("midrst_data", data_a, 0);
    check("midrst_no_valid", seen_a, sent_a);
    send_exp(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, CPB);
    wait_drain(0);

    send_exp(1, 8'h00, 1'b0, 1'b1, 1'b1, GL, 0);
    send_exp(1, 8'hFF, 1'b0, 1'b1, 1'b1, GL, CPB);
    wait_drain(1);
    check("b2b_count", seen_b, sent_b);

    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      p   = 1'($urandom_range(0, 1));
      s0  = ($urandom_range(0, 3) != 0);
      s1  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, CPB);
      if ((sel && !s1) || (!sel && !s0)) gap = 2 * CPB;
      send_exp(sel, d, p, s0, s1, GL, gap);
    end
    hold(CPB);
    wait_drain(0);
    wait_drain(1);
    check("total_a", seen_a, sent_a);
    check("total_b", seen_b, sent_b);
    check("final_data_b", data_b, last_b);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per bit (50 MHz / 9600 baud); legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port uart_rx  input  1  asynchronous serial line; idles high.
REQ-008 SHALL have port rx_data  output  DATA_BITS  last received word, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse marking a completed frame.
REQ-010 SHALL have port parity_err  output  1  parity mismatch for the frame flagged by rx_valid.
REQ-011 SHALL have port frame_err  output  1  a stop bit was sampled low in the frame flagged by rx_valid.
REQ-012 SHALL have port busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchroniser; the edge detector and all samplers use only the synchronised signal.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY==0.
REQ-015 IDLE: a synchronised 1->0 transition SHALL enter START, clear the bit-cycle counter, and set busy.
REQ-016 START: when the counter reaches CLKS_PER_BIT/2-1 (mid-bit), a high sample SHALL be a false start: return to IDLE, no rx_valid, no flag change.
REQ-017 A low mid-start sample SHALL clear the counter and enter DATA; every later bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, then the counter is cleared.
REQ-018 DATA SHALL shift DATA_BITS samples LSB-first, then go to PARITY or STOP.
REQ-019 PARITY SHALL sample one bit; odd mode errors when XOR of data and parity bits is 0, even mode when it is 1.
REQ-020 STOP SHALL sample STOP_BITS bits; any low sample sets the frame error.
REQ-021 On the final stop-bit sample the FSM SHALL return to IDLE (mid stop bit), allowing back-to-back frames with no idle gap.
REQ-022 In the cycle after the final stop-bit sample: rx_valid=1 for exactly one cycle; rx_data, parity_err and frame_err update together.
REQ-023 Frames with errors SHALL still deliver rx_valid and data; the flags qualify the frame.
REQ-024 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-025 A falling edge seen while not in IDLE SHALL be ignored.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, synchroniser and edge-history flops to 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, busy 0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame with no rx_valid; the first edge after rst deasserts starts a fresh frame.

Configuration
REQ-028 The macro UART_RX_MAJORITY_EN SHALL control the bit-sampling method.
- Defined: each bit value = 2-of-3 majority of samples at counter values target-1, target, target+1; the decision and the state advance occur at target+1.
- Undefined: single sample at target, with identical frame timing otherwise.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2), and the parameter-legality function.
REQ-030 Sub-module uart_rx_sampler SHALL contain the synchroniser, falling-edge detection and optional majority voter; the FSM, counter and shift register stay in uart_rx_param.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-031 8N1, send 0xA5 -> exactly one rx_valid, rx_data=0xA5, parity_err=0, frame_err=0, busy low the cycle after rx_valid.
REQ-032 Idle line with a 4-cycle low glitch -> no rx_valid; busy returns to 0 within 12 cycles of the glitch edge.
REQ-033 PARITY=2, send 0x07 with parity bit 0 -> rx_valid, rx_data=0x07, parity_err=1; then 0x07 with parity bit 1 -> parity_err=0.
REQ-034 Send 0x3C with stop bit 0 -> frame_err=1; next frame 0x81 -> rx_data=0x81, frame_err=0.
REQ-035 Assert rst during data bit 3 -> busy=0, rx_data=0, no rx_valid; next frame 0x55 -> rx_data=0x55.
REQ-036 Back-to-back 0x00 then 0xFF, no gap, STOP_BITS=2 -> two rx_valid pulses with correct data; with UART_RX_MAJORITY_EN, a 1-cycle inversion at a bit centre does not change rx_data.
